// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
//
// Purpose:
//    Upstream feeder for the 10110 sequence detector. Parallel words arrive
//    over a valid/ready handshake, one word is buffered in a holding
//    register, and the word is shifted out one bit per clock on idata,
//    qualified by data_en. An optional number of idle cycles (GAP) is
//    forced after every word.
//
// Parameters:
//    DATA_W     word width in bits (2..32)
//    MSB_FIRST  1: bit DATA_W-1 goes out first, 0: bit 0 goes out first
//    GAP        idle cycles forced after every word (0..15)
//
// Ports:
//    clk       rising-edge clock
//    reset     synchronous, active-high reset
//    pdata     parallel word, captured when pvalid && pready
//    pvalid    pdata is valid
//    pready    holding register empty, a word can be accepted
//    idata     serial bit, forced to 0 whenever data_en is 0
//    data_en   idata carries a valid bit this cycle
//    bit_last  high together with the final bit of each word
//    busy      shifting, in the gap, or holding register full
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pdata,
   input  logic              pvalid,
   output logic              pready,
   output logic              idata,
   output logic              data_en,
   output logic              bit_last,
   output logic              busy
);

   localparam int               CNT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST_IDX = CNT_W'(DATA_W - 1);
   localparam logic [3:0]       GAP_LAST_IDX = 4'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } StateType;

   StateType          state;
   StateType          stateNext;
   logic              loadShift;
   logic              holdValid;
   logic [DATA_W-1:0] holdReg;
   logic [DATA_W-1:0] shiftReg;
   logic [CNT_W-1:0]  bitCnt;
   logic [3:0]        gapCnt;
   logic              outBit;

   // The holding register can only take a word while it is empty, and never
   // while reset is asserted, so the source sees ready drop immediately.
   assign pready = !holdValid && !reset;

   // Anything in flight, including a word waiting in the holding register,
   // counts as busy.
   assign busy = (state != ST_IDLE) || holdValid;

   // The bit presented next is always the one at the leading end of the
   // shifter; the shift direction below keeps the next bit there.
   assign outBit = MSB_FIRST ? shiftReg[DATA_W-1] : shiftReg[0];

   // Next-state logic. loadShift marks every edge where the shifter takes the
   // held word; it doubles as the unload strobe for the holding register.
   // With GAP == 0 the last bit of one word can chain straight into the next
   // word so a full holding register streams without a bubble.
   always_comb begin
      stateNext = state;
      loadShift = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (holdValid) begin
               stateNext = ST_SHIFT;
               loadShift = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (bitCnt == BIT_LAST_IDX) begin
               if (GAP > 0) begin
                  stateNext = ST_GAP;
               end else if (holdValid) begin
                  stateNext = ST_SHIFT;
                  loadShift = 1'b1;
               end else begin
                  stateNext = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gapCnt == GAP_LAST_IDX) begin
               if (holdValid) begin
                  stateNext = ST_SHIFT;
                  loadShift = 1'b1;
               end else begin
                  stateNext = ST_IDLE;
               end
            end
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Holding register. A load and an accept can never coincide because
   // pready is low whenever there is something to load.
   always_ff @(posedge clk) begin
      if (reset) begin
         holdValid <= 1'b0;
         holdReg   <= '0;
      end else if (loadShift) begin
         holdValid <= 1'b0;
      end else if (pvalid && pready) begin
         holdValid <= 1'b1;
         holdReg   <= pdata;
      end
   end

   // Shifter and bit counter. The counter restarts on every load and parks
   // at zero after the final bit, so it never wraps inside a word whatever
   // DATA_W is.
   always_ff @(posedge clk) begin
      if (reset) begin
         shiftReg <= '0;
         bitCnt   <= '0;
      end else if (loadShift) begin
         shiftReg <= holdReg;
         bitCnt   <= '0;
      end else if (state == ST_SHIFT) begin
         shiftReg <= MSB_FIRST ? (shiftReg << 1) : (shiftReg >> 1);
         bitCnt   <= (bitCnt == BIT_LAST_IDX) ? '0 : (bitCnt + CNT_W'(1));
      end
   end

   // Gap counter: counts cycles spent in the gap state and is held at zero
   // everywhere else so each gap starts from a clean count.
   always_ff @(posedge clk) begin
      if (reset) begin
         gapCnt <= '0;
      end else if (state == ST_GAP) begin
         gapCnt <= gapCnt + 4'd1;
      end else begin
         gapCnt <= '0;
      end
   end

   // Registered serial outputs. They lag the shifter by one clock, which is
   // what gives the two-cycle accept-to-first-bit latency, and idata is
   // masked so the detector only ever sees 0 when data_en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         idata    <= 1'b0;
         data_en  <= 1'b0;
         bit_last <= 1'b0;
      end else begin
         data_en  <= (state == ST_SHIFT);
         idata    <= (state == ST_SHIFT) && outBit;
         bit_last <= (state == ST_SHIFT) && (bitCnt == BIT_LAST_IDX);
      end
   end

endmodule
